// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: word/mask aliases, arbiter
// state encoding and the latched request record that drives the physical port.
package mem_arbiter_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_INST = 2'd1,
      ARB_DATA = 2'd2
   } lc3b_arb_state;

   typedef struct packed {
      logic          read;
      logic          write;
      lc3b_mem_wmask wmask;
      lc3b_word      address;
      lc3b_word      wdata;
   } lc3b_mem_op;

   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one physical memory port, one
// transaction at a time; data wins ties unless fetch has waited STARVE_LIMIT grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                                clk,
   input  logic                                reset,
   // fetch port
   input  logic                                imem_read,
   input  logic [15:0]                         imem_address,
   output logic [15:0]                         imem_rdata,
   output logic                                imem_resp,
   // data port
   input  logic                                dmem_read,
   input  logic                                dmem_write,
   input  logic [1:0]                          dmem_wmask,
   input  logic [15:0]                         dmem_address,
   input  logic [15:0]                         dmem_wdata,
   output logic [15:0]                         dmem_rdata,
   output logic                                dmem_resp,
   // physical memory port
   output logic                                pmem_read,
   output logic                                pmem_write,
   output logic [1:0]                          pmem_wmask,
   output logic [15:0]                         pmem_address,
   output logic [15:0]                         pmem_wdata,
   input  logic [15:0]                         pmem_rdata,
   input  logic                                pmem_resp,
   // debug visibility of internal state
   output logic [1:0]                          arb_state_o,
   output logic [$clog2(STARVE_LIMIT+1)-1:0]   starve_cnt_o
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   lc3b_arb_state  state_q, state_d;
   lc3b_mem_op     req_q, req_d;
   logic [CW-1:0]  starve_q, starve_d;
   logic           data_req;
   logic           force_fetch;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         req_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         starve_q <= starve_d;
      end
   end

   assign data_req    = dmem_read | dmem_write;
   assign force_fetch = imem_read && (starve_q == LIMIT);

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      starve_d = starve_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (data_req && !force_fetch) begin
               state_d       = ARB_DATA;
               // a simultaneous read+write is serviced as the write alone
               req_d.read    = dmem_read & ~dmem_write;
               req_d.write   = dmem_write;
               req_d.wmask   = dmem_wmask;
               req_d.address = dmem_address;
               req_d.wdata   = dmem_wdata;
               if (!imem_read)
                  starve_d = '0;
               else if (starve_q != LIMIT)
                  starve_d = starve_q + CW'(1);
            end else if (imem_read) begin
               state_d       = ARB_INST;
               req_d.read    = 1'b1;
               req_d.write   = 1'b0;
               req_d.wmask   = '0;
               req_d.address = imem_address;
               req_d.wdata   = '0;
               starve_d      = '0;
            end
         end
         ARB_INST, ARB_DATA: begin
            if (pmem_resp)
               state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // the physical port only ever reflects the latched request
   assign pmem_read    = (state_q != ARB_IDLE) & req_q.read;
   assign pmem_write   = (state_q != ARB_IDLE) & req_q.write;
   assign pmem_wmask   = req_q.wmask;
   assign pmem_address = req_q.address;
   assign pmem_wdata   = req_q.wdata;

   assign imem_resp  = (state_q == ARB_INST) & pmem_resp;
   assign dmem_resp  = (state_q == ARB_DATA) & pmem_resp;
   assign imem_rdata = imem_resp ? pmem_rdata : '0;
   assign dmem_rdata = dmem_resp ? pmem_rdata : '0;

   assign arb_state_o  = state_q;
   assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table for single
// transactions and corner cases, plus a hand-written starvation sequence.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_read;
   logic [15:0] imem_address;
   logic [15:0] imem_rdata;
   logic        imem_resp;
   logic        dmem_read;
   logic        dmem_write;
   logic [1:0]  dmem_wmask;
   logic [15:0] dmem_address;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic [1:0]  pmem_wmask;
   logic [15:0] pmem_address;
   logic [15:0] pmem_wdata;
   logic [15:0] pmem_rdata;
   logic        pmem_resp;
   logic [1:0]  arb_state;
   logic [2:0]  starve_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_wmask   (dmem_wmask),
      .dmem_address (dmem_address),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wmask   (pmem_wmask),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .arb_state_o  (arb_state),
      .starve_cnt_o (starve_cnt)
   );

   // observed bus: {state, pr, pw, wmask, paddr, pwdata, iresp, irdata, dresp, drdata}
   typedef struct {
      string       name;
      logic        rst;
      logic        ir;
      logic [15:0] ia;
      logic        dr;
      logic        dw;
      logic [1:0]  wm;
      logic [15:0] da;
      logic [15:0] wd;
      logic        prsp;
      logic [15:0] prd;
      logic [71:0] exp_bus;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [71:0] act_bus();
      return {arb_state, pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
              imem_resp, imem_rdata, dmem_resp, dmem_rdata};
   endfunction

   task automatic add_vec(input string n, input logic rst, input logic ir, input logic [15:0] ia,
                          input logic dr, input logic dw, input logic [1:0] wm,
                          input logic [15:0] da, input logic [15:0] wd,
                          input logic prsp, input logic [15:0] prd,
                          input logic [1:0] st, input logic pr, input logic pw,
                          input logic [1:0] ewm, input logic [15:0] pa, input logic [15:0] pwd,
                          input logic irr, input logic [15:0] ird,
                          input logic drr, input logic [15:0] drd);
      vec_t v;
      v.name = n; v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.wm = wm;
      v.da = da; v.wd = wd; v.prsp = prsp; v.prd = prd;
      v.exp_bus = {st, pr, pw, ewm, pa, pwd, irr, ird, drr, drd};
      vecs.push_back(v);
   endtask

   task automatic check_bus(input string n, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic check_int(input string n, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic drive_idle();
      reset = 1'b0; imem_read = 1'b0; imem_address = '0;
      dmem_read = 1'b0; dmem_write = 1'b0; dmem_wmask = '0;
      dmem_address = '0; dmem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
   endtask

   initial begin
      int remaining, ndata, exp_starve;
      bit fetch_done;

      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);

      //       name            rst ir ia       dr dw wm     da       wd       prsp prd       st pr pw ewm    pa       pwd      ir ird      dr drd
      add_vec("reset",          1, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("fetch_req",      0, 1, 16'h10,  0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("fetch_wait1",    0, 1, 16'h10,  0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    1, 1, 0, 2'b00, 16'h10,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("fetch_wait2",    0, 1, 16'h10,  0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    1, 1, 0, 2'b00, 16'h10,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("fetch_resp",     0, 1, 16'h10,  0, 0, 2'b00, 16'h0,   16'h0,   1, 16'h1234, 1, 1, 0, 2'b00, 16'h10,  16'h0,   1, 16'h1234, 0, 16'h0);
      add_vec("fetch_idle",     0, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b00, 16'h10,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("both_req",       0, 1, 16'h20,  0, 1, 2'b11, 16'h400, 16'hBEEF, 0, 16'h0,   0, 0, 0, 2'b00, 16'h10,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("write_first",    0, 1, 16'h20,  0, 1, 2'b11, 16'h400, 16'hBEEF, 1, 16'h5555, 2, 0, 1, 2'b11, 16'h400, 16'hBEEF, 0, 16'h0, 1, 16'h5555);
      add_vec("then_idle",      0, 1, 16'h20,  0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b11, 16'h400, 16'hBEEF, 0, 16'h0,   0, 16'h0);
      add_vec("then_fetch",     0, 1, 16'h20,  0, 0, 2'b00, 16'h0,   16'h0,   1, 16'hABCD, 1, 1, 0, 2'b00, 16'h20,  16'h0,   1, 16'hABCD, 0, 16'h0);
      add_vec("after_fetch",    0, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b00, 16'h20,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("rw_req",         0, 0, 16'h0,   1, 1, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,   0, 0, 0, 2'b00, 16'h20,  16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("rw_as_write",    0, 0, 16'h0,   1, 1, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,   2, 0, 1, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,  0, 16'h0);
      add_vec("inputs_change",  0, 0, 16'h0,   0, 0, 2'b10, 16'h999, 16'h1111, 0, 16'h0,   2, 0, 1, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,  0, 16'h0);
      add_vec("dropped_resp",   0, 0, 16'h0,   0, 0, 2'b10, 16'h999, 16'h1111, 1, 16'h7777, 2, 0, 1, 2'b01, 16'h102, 16'h00FF, 0, 16'h0, 1, 16'h7777);
      add_vec("idle_resp_ign",  0, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   1, 16'h1111, 0, 0, 0, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,  0, 16'h0);
      add_vec("read_req",       0, 0, 16'h0,   1, 0, 2'b00, 16'h200, 16'h0,   0, 16'h0,    0, 0, 0, 2'b01, 16'h102, 16'h00FF, 0, 16'h0,  0, 16'h0);
      add_vec("reset_in_data",  1, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    2, 1, 0, 2'b00, 16'h200, 16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("late_resp_ign",  0, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   1, 16'h2222, 0, 0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,   0, 16'h0);
      add_vec("quiet_after",    0, 0, 16'h0,   0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,    0, 0, 0, 2'b00, 16'h0,   16'h0,   0, 16'h0,   0, 16'h0);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset = vecs[i].rst; imem_read = vecs[i].ir; imem_address = vecs[i].ia;
         dmem_read = vecs[i].dr; dmem_write = vecs[i].dw; dmem_wmask = vecs[i].wm;
         dmem_address = vecs[i].da; dmem_wdata = vecs[i].wd;
         pmem_resp = vecs[i].prsp; pmem_rdata = vecs[i].prd;
         @(negedge clk);
         check_bus(vecs[i].name, act_bus(), vecs[i].exp_bus);
      end
      check_int("starve_after_reset", int'(starve_cnt), 0);

      // starvation: fetch held while five data reads queue back to back
      drive_idle();
      imem_read = 1'b1; imem_address = 16'h0030;
      dmem_read = 1'b1; dmem_address = 16'h0400;
      remaining = 5; ndata = 0; fetch_done = 1'b0;
      for (int cyc = 0; cyc < 80 && (remaining > 0 || !fetch_done); cyc++) begin
         @(negedge clk);
         pmem_resp  = pmem_read | pmem_write;
         pmem_rdata = 16'h0F0F;
         #1;
         if (dmem_resp) begin
            ndata++;
            exp_starve = fetch_done ? 0 : ndata;
            check_int("starve_after_data", int'(starve_cnt), exp_starve);
            remaining--;
            if (remaining == 0) dmem_read = 1'b0;
            else dmem_address = dmem_address + 16'h2;
         end
         if (imem_resp) begin
            check_int("data_grants_before_fetch", ndata, 4);
            check_int("starve_after_fetch", int'(starve_cnt), 0);
            fetch_done = 1'b1;
            imem_read  = 1'b0;
         end
      end
      check_int("fetch_served", int'(fetch_done), 1);
      check_int("data_reads_served", ndata, 5);
      @(negedge clk);
      pmem_resp = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
